ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
Parametrised execute unit for the RV M-extension: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Sits beside the single-cycle EX stage; ID dispatches M-ops here via a valid/ready handshake.
- Multi-cycle iterative datapath (shift-add multiply, restoring divide). Back-pressures ID while busy.
- Result returns to MEM/WB through a registered valid/ready output.

Parameters:
XLEN, 32, operand/result width (power of two, >= 8)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous active-high reset
rdy_in  input  1  global enable; low freezes all state (outputs hold)
flush  input  1  pipeline flush (mispredict); aborts any operation
in_valid  input  1  ID presents an M-op
in_ready  output  1  unit can accept (state IDLE)
op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_val  input  XLEN  operand 1
rs2_val  input  XLEN  operand 2
rd_addr_in  input  5  destination register
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
rd_addr  output  5  destination of result
rd_val  output  XLEN  result
busy  output  1  high in MUL, DIV or DONE; ID uses it as stall_id

Behaviour:
- Reset (async, rst_in=1): state=IDLE, counter=0, out_valid=0, rd_addr=0, rd_val=0, busy=0. Internal accumulators are cleared.
- All updates are on posedge clk_in and only when rdy_in=1. When rdy_in=0, nothing changes.
- States: IDLE, MUL, DIV, DONE.
- IDLE: in_ready=1. An accept occurs when in_valid=1 and flush=0.
  - op[2]=0: go to MUL.
  - op[2]=1 with a special case: go directly to DONE.
  - op[2]=1 otherwise: go to DIV.
  - On accept, latch op and rd_addr_in. Latch operand magnitudes and the result sign.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - Signed operands are converted to absolute value. The unsigned core result is negated at the end when required.
  - Quotient sign = sign1 XOR sign2. Remainder sign = sign1.
- MUL: one partial-product bit per cycle, XLEN cycles, into a 2*XLEN accumulator.
  - MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits.
- DIV: restoring, one quotient bit per cycle, XLEN cycles.
- Special cases (DONE one cycle after accept):
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = rs1_val.
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): DIV result = -2^(XLEN-1); REM result = 0.
- Latency from accept edge to out_valid=1:
  - MUL/DIV: XLEN+1 cycles.
  - Special cases: 1 cycle.
- DONE: out_valid=1; rd_val and rd_addr are stable.
  - Leave for IDLE when out_ready=1. There is no back-to-back accept in the same cycle; in_ready is 0 in DONE.
  - out_valid stays high and the data holds until out_ready=1.
- flush=1 in any state: next state IDLE, out_valid=0, counter=0. No result is produced. An in_valid in the same cycle is ignored.
- flush has priority over out_ready and in_valid. rst_in has priority over everything.
- rd_addr_in=0: the unit computes normally and outputs rd_addr=0; writeback discards it.
- busy = (state != IDLE). in_ready = (state == IDLE).

Optional Feature:
FAST_MUL_EN
- Defined: the MUL state is removed. Multiply uses a single combinational 2*XLEN product registered on accept, so MUL* latency = 1 cycle. Divide is unchanged.
- Undefined: iterative multiply, XLEN+1 cycles.

Test Plan:
- MUL rs1=7, rs2=-3, rd=5 (XLEN=32) -> out_valid after 33 cycles, rd_val=0xFFFFFFEB, rd_addr=5. With FAST_MUL_EN: after 1 cycle.
- MULH/MULHSU/MULHU with rs1=0x80000000, rs2=0xFFFFFFFF -> 0x00000000 / 0x80000000 / 0x7FFFFFFF respectively.
- DIV rs1=-7, rs2=2 -> 0xFFFFFFFD. REM rs1=-7, rs2=2 -> 0xFFFFFFFF. DIVU rs1=100, rs2=7 -> 14. REMU rs1=100, rs2=7 -> 2. Each after 33 cycles.
- DIVU rs2=0 -> 0xFFFFFFFF after 1 cycle. REM rs1=0x12345678, rs2=0 -> 0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- Back-pressure and freeze: hold out_ready=0 for 5 cycles in DONE -> out_valid and rd_val held, in_ready=0. Drop rdy_in for 3 cycles mid-DIV -> latency extends by exactly 3 cycles and the result is unchanged.
- flush at cycle 10 of a DIV -> next cycle IDLE, out_valid never asserts. Assert rst_in asynchronously mid-MUL -> outputs zero immediately. A new op after release completes correctly.

Source files
------------

// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv_if
//  Purpose  : Dispatch / result handshake bundle between ID, the M-extension
//             execute unit and MEM/WB. master = pipeline side,
//             slave = ex_muldiv side.
//  Revision : 1.0  initial release
// ============================================================================
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    // Dispatch side (ID -> unit)
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_addr_in;

    // Result side (unit -> MEM/WB)
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_val;

    // Stall request towards ID
    logic            busy;

    modport master (
        output in_valid, op, rs1_val, rs2_val, rd_addr_in, out_ready,
        input  in_ready, out_valid, rd_addr, rd_val, busy
    );

    modport slave (
        input  in_valid, op, rs1_val, rs2_val, rd_addr_in, out_ready,
        output in_ready, out_valid, rd_addr, rd_val, busy
    );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv
//  Purpose  : RV M-extension execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/
//             REM/REMU). Iterative shift-add multiply and restoring divide on
//             operand magnitudes, with the sign applied to the final result.
//             Divide-by-zero and signed overflow complete one cycle after
//             accept.
//  Options  : `define FAST_MUL_EN -> single-cycle combinational multiply,
//             registered on accept; the iterative MUL state is not built.
//  Revision : 1.0  initial release
// ============================================================================
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  wire logic    clk_in,
    input  wire logic    rst_in,
    input  wire logic    rdy_in,
    input  wire logic    flush,
    ex_muldiv_if.slave   bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    // Counter value of the final iteration (XLEN iterations, counted 0..XLEN-1)
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  c_int_min  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_op;        // funct3[1:0]; the mul/div choice lives in the state
    logic              r_neg;       // final result must be negated
    logic [XLEN-1:0]   r_opnd;      // multiplicand (MUL) or divisor (DIV) magnitude
    logic [2*XLEN-1:0] r_acc;       // MUL: {partial hi, multiplier}; DIV: {remainder, dividend/quotient}
    logic              r_out_valid;
    logic [4:0]        r_rd_addr;
    logic [XLEN-1:0]   r_rd_val;

    logic              w_s1_signed;
    logic              w_s2_signed;
    logic              w_sign1;
    logic              w_sign2;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic              w_neg_res;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_val;

    // Operand signedness per funct3, magnitudes and the sign the result will carry
    always_comb begin
        w_s1_signed = 1'b0;
        w_s2_signed = 1'b0;
        case (bus.op)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                w_s1_signed = 1'b1;
                w_s2_signed = 1'b1;
            end
            3'd2:    w_s1_signed = 1'b1;
            default: ;
        endcase
        w_sign1   = w_s1_signed & bus.rs1_val[XLEN-1];
        w_sign2   = w_s2_signed & bus.rs2_val[XLEN-1];
        w_mag1    = w_sign1 ? -bus.rs1_val : bus.rs1_val;
        w_mag2    = w_sign2 ? -bus.rs2_val : bus.rs2_val;
        // Remainder follows the dividend; quotient and product follow sign1^sign2
        w_neg_res = (bus.op[2] & bus.op[1]) ? w_sign1 : (w_sign1 ^ w_sign2);
    end

    // Divide special cases resolved at accept time
    always_comb begin
        w_div0        = bus.op[2] & (bus.rs2_val == '0);
        w_ovf         = bus.op[2] & ~bus.op[0] &
                        (bus.rs1_val == c_int_min) & (bus.rs2_val == '1);
        w_special     = w_div0 | w_ovf;
        w_special_val = '0;
        if (w_div0)
            w_special_val = bus.op[1] ? bus.rs1_val : '1;
        else if (w_ovf)
            w_special_val = bus.op[1] ? '0 : c_int_min;
    end

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_prod;
    logic [2*XLEN-1:0] w_fast_full;
    logic [XLEN-1:0]   w_fast_res;

    // Whole product in one cycle, signed fix-up and half selection from live inputs
    always_comb begin
        w_fast_prod = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
        w_fast_full = w_neg_res ? -w_fast_prod : w_fast_prod;
        w_fast_res  = (bus.op[1:0] == 2'd0) ? w_fast_full[XLEN-1:0]
                                            : w_fast_full[2*XLEN-1:XLEN];
    end
`else
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [2*XLEN-1:0] w_mul_full;
    logic [XLEN-1:0]   w_mul_res;

    // One shift-add step; the result is taken from the post-step accumulator
    // so the final step and the result register share the same edge
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                     (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
        w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
        w_mul_full = r_neg ? -w_mul_next : w_mul_next;
        w_mul_res  = (r_op == 2'd0) ? w_mul_full[XLEN-1:0]
                                    : w_mul_full[2*XLEN-1:XLEN];
    end
`endif

    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_trial;
    logic [2*XLEN-1:0] w_div_next;
    logic [XLEN-1:0]   w_div_core;
    logic [XLEN-1:0]   w_div_res;

    // One restoring-divide step: shift in the next dividend bit, keep the
    // subtraction only when it does not borrow
    always_comb begin
        w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_div_trial = w_div_shift - {1'b0, r_opnd};
        if (w_div_trial[XLEN])
            w_div_next = {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        else
            w_div_next = {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        w_div_core = r_op[1] ? w_div_next[2*XLEN-1:XLEN] : w_div_next[XLEN-1:0];
        w_div_res  = r_neg ? -w_div_core : w_div_core;
    end

    // Control FSM and datapath registers; rdy_in low freezes everything
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_neg       <= 1'b0;
            r_opnd      <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_val    <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                r_state     <= S_IDLE;
                r_out_valid <= 1'b0;
                r_cnt       <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.in_valid) begin
                            r_op      <= bus.op[1:0];
                            r_rd_addr <= bus.rd_addr_in;
                            r_neg     <= w_neg_res;
                            r_cnt     <= '0;
                            if (!bus.op[2]) begin
`ifdef FAST_MUL_EN
                                r_rd_val    <= w_fast_res;
                                r_out_valid <= 1'b1;
                                r_state     <= S_DONE;
`else
                                r_acc   <= {{XLEN{1'b0}}, w_mag2};
                                r_opnd  <= w_mag1;
                                r_state <= S_MUL;
`endif
                            end else if (w_special) begin
                                r_rd_val    <= w_special_val;
                                r_out_valid <= 1'b1;
                                r_state     <= S_DONE;
                            end else begin
                                r_acc   <= {{XLEN{1'b0}}, w_mag1};
                                r_opnd  <= w_mag2;
                                r_state <= S_DIV;
                            end
                        end
                    end
`ifndef FAST_MUL_EN
                    S_MUL: begin
                        r_acc <= w_mul_next;
                        if (r_cnt == c_last_cnt) begin
                            r_rd_val    <= w_mul_res;
                            r_out_valid <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
`endif
                    S_DIV: begin
                        r_acc <= w_div_next;
                        if (r_cnt == c_last_cnt) begin
                            r_rd_val    <= w_div_res;
                            r_out_valid <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (bus.out_ready) begin
                            r_out_valid <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.rd_val    = r_rd_val;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_muldiv
//  Purpose  : Self-checking bench for ex_muldiv: directed corner cases plus
//             randomized operations compared against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_muldiv;
    localparam int XLEN = 32;
    localparam logic [31:0] c_min = 32'h8000_0000;

    logic clk;
    logic rst;
    logic rdy;
    logic flush;

    int n_checks = 0;
    int n_pass   = 0;

    ex_muldiv_if #(.XLEN(XLEN)) bus ();

    ex_muldiv #(.XLEN(XLEN)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .flush  (flush),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Architectural result from plain 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint     sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        case (op)
            3'd0: begin p = sa * sb;              return p[31:0];  end
            3'd1: begin p = sa * sb;              return p[63:32]; end
            3'd2: begin p = sa * longint'(ub);    return p[63:32]; end
            3'd3: begin p = ua * ub;              return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == c_min && b == 32'hFFFF_FFFF) return c_min;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == c_min && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Cycles from the accept edge until out_valid is seen
    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!op[2]) begin
`ifdef FAST_MUL_EN
            return 1;
`else
            return XLEN + 1;
`endif
        end
        if (b == 32'd0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == c_min && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return c_min;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Wait (bounded) for IDLE, then present one op for a single cycle
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        int cyc;
        cyc = 0;
        while (!bus.in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("in_ready_before_op", 64'(bus.in_ready), 64'd1);
        bus.in_valid   = 1'b1;
        bus.op         = op;
        bus.rs1_val    = a;
        bus.rs2_val    = b;
        bus.rd_addr_in = rd;
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.rs1_val    = 32'($urandom);
        bus.rs2_val    = 32'($urandom);
    endtask

    // Full operation: optional rdy_in stall, optional out_ready hold in DONE
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int stall_at, input int stall_len,
                          input int hold);
        int          cyc;
        int          exp_lat;
        logic [31:0] exp_v;
        exp_v   = ref_result(op, a, b);
        exp_lat = ref_latency(op, a, b) + stall_len;
        bus.out_ready = (hold == 0);
        start_op(op, a, b, rd);
        check("busy_after_accept", 64'(bus.busy), 64'd1);
        cyc = 1;
        while (!bus.out_valid && cyc < 200) begin
            if (stall_len > 0 && cyc == stall_at)             rdy = 1'b0;
            if (stall_len > 0 && cyc == stall_at + stall_len) rdy = 1'b1;
            @(negedge clk);
            cyc++;
        end
        rdy = 1'b1;
        check($sformatf("latency op%0d", op), 64'(cyc), 64'(exp_lat));
        check($sformatf("rd_val op%0d a=%h b=%h", op, a, b), 64'(bus.rd_val), 64'(exp_v));
        check("rd_addr", 64'(bus.rd_addr), 64'(rd));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_out_valid", 64'(bus.out_valid), 64'd1);
            check("hold_rd_val", 64'(bus.rd_val), 64'(exp_v));
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("out_valid_drops", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        int seen;
        rst            = 1'b1;
        rdy            = 1'b1;
        flush          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.op         = 3'd0;
        bus.rs1_val    = 32'd0;
        bus.rs2_val    = 32'd0;
        bus.rd_addr_in = 5'd0;
        bus.out_ready  = 1'b1;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_rd_val",    64'(bus.rd_val),    64'd0);
        check("rst_rd_addr",   64'(bus.rd_addr),   64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, 0, 5);
        run_op(3'd1, c_min, 32'hFFFF_FFFF, 5'd1, 0, 0, 0);
        run_op(3'd2, c_min, 32'hFFFF_FFFF, 5'd2, 0, 0, 0);
        run_op(3'd3, c_min, 32'hFFFF_FFFF, 5'd3, 0, 0, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, 0, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 0, 0);
        run_op(3'd5, 32'd100, 32'd7, 5'd7, 0, 0, 0);
        run_op(3'd7, 32'd100, 32'd7, 5'd8, 0, 0, 0);
        run_op(3'd5, 32'd55, 32'd0, 5'd9, 0, 0, 0);
        run_op(3'd6, 32'h1234_5678, 32'd0, 5'd10, 0, 0, 0);
        run_op(3'd4, c_min, 32'hFFFF_FFFF, 5'd11, 0, 0, 0);
        run_op(3'd6, c_min, 32'hFFFF_FFFF, 5'd0, 0, 0, 0);
        run_op(3'd4, 32'd1000, 32'hFFFF_FFF9, 5'd12, 5, 3, 0);

        // Flush at cycle 10 of a divide: back to IDLE, no result ever
        start_op(3'd5, 32'd1000, 32'd3, 5'd13);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        check("flush_busy",     64'(bus.busy),     64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check("flush_no_result", 64'(seen), 64'd0);

        // in_valid together with flush is not accepted
        bus.in_valid = 1'b1;
        bus.op       = 3'd0;
        flush        = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        check("flush_blocks_accept", 64'(bus.busy), 64'd0);

        // Asynchronous reset in the middle of a multiply
        start_op(3'd0, 32'd123, 32'd456, 5'd14);
        repeat (7) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy",      64'(bus.busy),      64'd0);
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_rd_val",    64'(bus.rd_val),    64'd0);
        check("arst_rd_addr",   64'(bus.rd_addr),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(3'd0, 32'd123, 32'd456, 5'd15, 0, 0, 0);

        // Randomized operations against the model
        for (int n = 0; n < 40; n++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   5'($urandom_range(0, 31)), 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
